norm_seq_ctrl: RTL and testbench
================================

Name: norm_seq_ctrl

Overview:
- Sequential normalization controller for the floating-point add/sub datapath; sits between the mantissa adder and result packing.
- Accepts one raw sum word {zero, sign, carry, man[22:0]} plus the pre-normalization exponent.
- Normalizes with at most one right shift, or iterative left shifts at one bit per cycle, adjusting the exponent as it goes.
- Uses valid/ready handshakes on both sides and bounds the shift loop, so all-zero mantissas and exponent underflow terminate.

Parameters:
MAN_W, 23, mantissa width excluding hidden bit
EXP_W, 8, exponent width
CNT_W, 8, shift-count width; must hold MAN_W

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  raw sum and exponent are valid
in_ready  output  1  controller can accept a new operand
in_val  input  MAN_W+3  {zero, sign, carry, man}
in_exp  input  EXP_W  exponent before normalization
out_valid  output  1  result valid
out_ready  input  1  downstream accepts the result
out_norm  output  MAN_W+1  {sign, normalized man}
out_exp  output  EXP_W  adjusted exponent
out_shift  output  CNT_W+1  {dir, count}: dir=1 means left shift by count; 9'h001 means one right shift; 9'h000 means none
out_zero  output  1  result is zero
out_uflow  output  1  exponent reached 0 before normalization completed
out_oflow  output  1  right shift took the exponent to all-ones
busy  output  1  state is not IDLE

Behaviour:
- Reset (async assert, synchronous release): state IDLE, in_ready=1, out_valid=0, all other outputs 0, internal registers 0. Assertion mid-operation aborts the operation immediately; the result is discarded.
- States: IDLE, LSHIFT, DONE.
- IDLE:
  - in_ready=1.
  - Accept occurs on in_valid & in_ready; register sign, man, exp; clear count.
  - Classification priority, highest first:
    (1) zero=1 -> out_norm={sign,0}, exp=0, shift=0, out_zero=1; go to DONE.
    (2) carry=1 -> man={1'b1, man[MAN_W-1:1]}, exp+1, shift=9'h001; out_oflow=1 if the new exp is all-ones; go to DONE.
    (3) man==0 -> treat as case (1) and set out_zero=1.
    (4) man[MSB]=1 -> no shift, shift=9'h000; go to DONE.
    (5) Otherwise: if exp==0, set out_uflow=1, shift=9'h000, go to DONE; else go to LSHIFT.
- LSHIFT:
  - in_ready=0.
  - Each cycle: man<<=1, exp-=1, count+=1.
  - Leave for DONE when the new man[MSB]=1, or when the new exp==0 and man[MSB]=0; in the second case set out_uflow=1.
  - Result: shift={1'b1, count}.
  - count never exceeds MAN_W-1, because man!=0 is guaranteed on entry.
- DONE:
  - out_valid=1; outputs stay stable until out_ready.
  - On out_valid & out_ready, go to IDLE and drop out_valid. The flags drop with it.
- Latency, counted from the accept edge:
  - Cases (1)-(4), and case (5) with exp==0: out_valid is high after 1 cycle.
  - k left shifts: out_valid is high after 1+k cycles.
- Throughput: one operand in flight. in_ready=0 in LSHIFT and DONE. No new accept happens in the cycle the result handshakes; the next accept is in IDLE.
- Simultaneous events:
  - in_valid held during busy is ignored and not lost; the producer must hold it.
  - out_ready asserted before out_valid has no effect.
- Arithmetic:
  - Exponent add/sub is modulo 2^EXP_W internally.
  - Overflow and underflow are reported by flags only, never by wraparound in out_exp: underflow stops at 0, and overflow yields all-ones.

Test Plan:
- Left normalize: in_val={0,0,0,23'h000100}, in_exp=100 -> after 15 cycles out_norm=24'h400000, out_exp=86, out_shift=9'h10E; no flags.
- Carry right shift: in_val={0,1,1,23'h000003}, in_exp=10 -> after 1 cycle out_norm=24'hC00001, out_exp=11, out_shift=9'h001. Repeat with in_exp=254 -> out_exp=255, out_oflow=1.
- Zero paths:
  - in_val[25]=1 with sign=1 -> out_norm=24'h800000, out_exp=0, out_zero=1, latency 1.
  - in_val={0,0,0,0} -> out_zero=1, no LSHIFT cycles.
- Underflow: in_val={0,0,0,23'h000001}, in_exp=5 -> after 6 cycles out_norm=24'h000020, out_exp=0, out_shift=9'h105, out_uflow=1. Also in_exp=0 with man=23'h000100 -> uflow=1 and shift=0 after 1 cycle.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, and a pending in_valid is not accepted.
  - Assert rst_n=0 during LSHIFT on shift 3 of 14 -> out_valid=0 immediately, in_ready=1 after release, and the next operand processes correctly.

Source files
------------

// File: rtl/norm_seq_ctrl.sv
// Normalization controller for the FP add/sub datapath: one right shift on carry,
// or one-bit-per-cycle left shifts until the hidden-bit position is set or the exponent reaches 0.
module norm_seq_ctrl #(
  parameter int MAN_W = 23,
  parameter int EXP_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAN_W+2:0] in_val,
  input  logic [EXP_W-1:0] in_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAN_W:0]   out_norm,
  output logic [EXP_W-1:0] out_exp,
  output logic [CNT_W:0]   out_shift,
  output logic             out_zero,
  output logic             out_uflow,
  output logic             out_oflow,
  output logic             busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LSHIFT = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             sign_q, sign_d;
  logic [MAN_W-1:0] man_q, man_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   shift_q, shift_d;
  logic             zero_q, zero_d;
  logic             uflow_q, uflow_d;
  logic             oflow_q, oflow_d;

  logic             in_zero, in_sign, in_carry;
  logic [MAN_W-1:0] in_man;

  assign in_zero  = in_val[MAN_W+2];
  assign in_sign  = in_val[MAN_W+1];
  assign in_carry = in_val[MAN_W];
  assign in_man   = in_val[MAN_W-1:0];

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // in_ready is high only in IDLE, out_valid only in DONE, so accept and result never coincide.
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    man_d   = man_q;
    exp_d   = exp_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    zero_d  = zero_q;
    uflow_d = uflow_q;
    oflow_d = oflow_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sign_d  = in_sign;
          man_d   = in_man;
          exp_d   = in_exp;
          cnt_d   = '0;
          shift_d = '0;
          zero_d  = 1'b0;
          uflow_d = 1'b0;
          oflow_d = 1'b0;
          state_d = ST_DONE;
          if (in_zero || (!in_carry && in_man == '0)) begin
            man_d  = '0;
            exp_d  = '0;
            zero_d = 1'b1;
          end else if (in_carry) begin
            man_d   = {1'b1, in_man[MAN_W-1:1]};
            shift_d = {{CNT_W{1'b0}}, 1'b1};
            // Saturate instead of wrapping; the flag carries the overflow information.
            if (in_exp == '1) exp_d = '1;
            else              exp_d = in_exp + EXP_W'(1);
            oflow_d = (exp_d == '1);
          end else if (in_man[MAN_W-1]) begin
            shift_d = '0;
          end else if (in_exp == '0) begin
            uflow_d = 1'b1;
          end else begin
            state_d = ST_LSHIFT;
          end
        end
      end
      ST_LSHIFT: begin
        man_d   = {man_q[MAN_W-2:0], 1'b0};
        exp_d   = exp_q - EXP_W'(1);
        cnt_d   = cnt_q + CNT_W'(1);
        shift_d = {1'b1, cnt_d};
        if (man_d[MAN_W-1]) begin
          state_d = ST_DONE;
        end else if (exp_d == '0) begin
          uflow_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
          zero_d  = 1'b0;
          uflow_d = 1'b0;
          oflow_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sign_q  <= 1'b0;
      man_q   <= '0;
      exp_q   <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      zero_q  <= 1'b0;
      uflow_q <= 1'b0;
      oflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      man_q   <= man_d;
      exp_q   <= exp_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      zero_q  <= zero_d;
      uflow_q <= uflow_d;
      oflow_q <= oflow_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_norm  = {sign_q, man_q};
  assign out_exp   = exp_q;
  assign out_shift = shift_q;
  assign out_zero  = zero_q;
  assign out_uflow = uflow_q;
  assign out_oflow = oflow_q;

endmodule

// File: tb/tb_norm_seq_ctrl.sv
// Directed bench for norm_seq_ctrl: vector table with hand-computed results,
// plus backpressure and mid-shift reset sequences.
module tb_norm_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [25:0] in_val;
  logic [7:0]  in_exp;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_norm;
  logic [7:0]  out_exp;
  logic [8:0]  out_shift;
  logic        out_zero;
  logic        out_uflow;
  logic        out_oflow;
  logic        busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [25:0] v;
    logic [7:0]  e;
    logic [23:0] norm;
    logic [7:0]  exp;
    logic [8:0]  sh;
    logic        z;
    logic        u;
    logic        o;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  norm_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_val    (in_val),
    .in_exp    (in_exp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_norm  (out_norm),
    .out_exp   (out_exp),
    .out_shift (out_shift),
    .out_zero  (out_zero),
    .out_uflow (out_uflow),
    .out_oflow (out_oflow),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t t, input bit early);
    int lat;
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 1);
    in_valid  = 1'b1;
    in_val    = t.v;
    in_exp    = t.e;
    out_ready = early;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(t.lat));
    chk("out_valid", 32'(out_valid), 1);
    chk("out_norm", 32'(out_norm), 32'(t.norm));
    chk("out_exp", 32'(out_exp), 32'(t.exp));
    chk("out_shift", 32'(out_shift), 32'(t.sh));
    chk("out_flags", {29'd0, out_zero, out_uflow, out_oflow}, {29'd0, t.z, t.u, t.o});
    chk("in_ready_done", 32'(in_ready), 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_drop", 32'(out_valid), 0);
    chk("flags_drop", {29'd0, out_zero, out_uflow, out_oflow}, 0);
    chk("in_ready_back", 32'(in_ready), 1);
  endtask

  initial begin
    //          {z,s,c,man}                 exp     norm        exp    shift   z  u  o  lat
    vecs[0] = '{{3'b000, 23'h000100}, 8'd100, 24'h400000, 8'd86,  9'h10E, 0, 0, 0, 15};
    vecs[1] = '{{3'b011, 23'h000003}, 8'd10,  24'hC00001, 8'd11,  9'h001, 0, 0, 0, 1};
    vecs[2] = '{{3'b011, 23'h000003}, 8'd254, 24'hC00001, 8'd255, 9'h001, 0, 0, 1, 1};
    vecs[3] = '{{3'b110, 23'h123456}, 8'd77,  24'h800000, 8'd0,   9'h000, 1, 0, 0, 1};
    vecs[4] = '{{3'b000, 23'h000000}, 8'd50,  24'h000000, 8'd0,   9'h000, 1, 0, 0, 1};
    vecs[5] = '{{3'b000, 23'h000001}, 8'd5,   24'h000020, 8'd0,   9'h105, 0, 1, 0, 6};
    vecs[6] = '{{3'b000, 23'h000100}, 8'd0,   24'h000100, 8'd0,   9'h000, 0, 1, 0, 1};
    vecs[7] = '{{3'b010, 23'h400ABC}, 8'd33,  24'hC00ABC, 8'd33,  9'h000, 0, 0, 0, 1};
    vecs[8] = '{{3'b000, 23'h000001}, 8'd22,  24'h400000, 8'd0,   9'h116, 0, 0, 0, 23};
    vecs[9] = '{{3'b101, 23'h000005}, 8'd9,   24'h000000, 8'd0,   9'h000, 1, 0, 0, 1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_val    = '0;
    in_exp    = '0;
    out_ready = 1'b0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_data", {out_norm, out_exp}, 0);
    chk("rst_shift_flags", {20'd0, out_shift, out_zero, out_uflow, out_oflow}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_op(vecs[i], (i % 2) == 1);

    // Backpressure: result held 5 cycles while another operand waits.
    @(negedge clk);
    in_valid = 1'b1;
    in_val   = vecs[1].v;
    in_exp   = vecs[1].e;
    @(negedge clk);
    in_val = vecs[4].v;
    in_exp = vecs[4].e;
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_norm", 32'(out_norm), 32'h00C00001);
      chk("bp_exp", 32'(out_exp), 11);
      chk("bp_in_ready", 32'(in_ready), 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release_valid", 32'(out_valid), 0);
    chk("bp_release_ready", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_pending_valid", 32'(out_valid), 1);
    chk("bp_pending_zero", 32'(out_zero), 1);
    chk("bp_pending_exp", 32'(out_exp), 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_pending_drop", 32'(out_valid), 0);

    // Reset during the left-shift loop, then a clean operation.
    @(negedge clk);
    in_valid = 1'b1;
    in_val   = vecs[0].v;
    in_exp   = vecs[0].e;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ready", 32'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 32'(out_valid), 0);
    run_op(vecs[5], 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
